// File: rtl/btn_conditioner.sv
// Multi-channel pushbutton conditioner: synchroniser, debouncer, press/release
// edge pulses and optional auto-repeat per channel, all sharing one timing set.
module btn_conditioner #(
    parameter int unsigned N_CH        = 5,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DB_COUNT    = 1_000_000,
    parameter int unsigned RPT_DELAY   = 32_500_000,
    parameter int unsigned RPT_PERIOD  = 6_500_000
) (
    input  logic            clk_in,
    input  logic            reset_in,
    input  logic [N_CH-1:0] noisy_in,
    input  logic [N_CH-1:0] rpt_en,
    output logic [N_CH-1:0] clean_out,
    output logic [N_CH-1:0] press_pulse,
    output logic [N_CH-1:0] release_pulse,
    output logic [N_CH-1:0] step_pulse
);

    localparam int unsigned DW      = $clog2(DB_COUNT + 1);
    localparam int unsigned RPT_MAX = (RPT_DELAY > RPT_PERIOD) ? RPT_DELAY : RPT_PERIOD;
    localparam int unsigned RW      = $clog2(RPT_MAX + 1);

    localparam logic [DW-1:0] DB_LAST = DW'(DB_COUNT - 1);
    localparam logic [DW-1:0] DB_SAT  = DW'(DB_COUNT);
    localparam logic [RW-1:0] RPT_DLY = RW'(RPT_DELAY);
    localparam logic [RW-1:0] RPT_PER = RW'(RPT_PERIOD);

    typedef enum logic [1:0] {
        RPT_IDLE,
        RPT_DELAY_ST,
        RPT_REPEAT
    } rpt_state_e;

    logic [N_CH-1:0] sync_q [SYNC_STAGES];
    logic [N_CH-1:0] sync_d [SYNC_STAGES];
    logic [N_CH-1:0] sync;

    logic [N_CH-1:0] cand_q, cand_d;
    logic [N_CH-1:0] clean_q, clean_d;
    logic [N_CH-1:0] press_q, press_d;
    logic [N_CH-1:0] release_q, release_d;
    logic [N_CH-1:0] step_q, step_d;
    logic [N_CH-1:0] rpt_d;

    logic [DW-1:0]   db_cnt_q  [N_CH];
    logic [DW-1:0]   db_cnt_d  [N_CH];
    logic [RW-1:0]   rpt_cnt_q [N_CH];
    logic [RW-1:0]   rpt_cnt_d [N_CH];
    logic [RW-1:0]   rpt_inc   [N_CH];
    rpt_state_e      state_q   [N_CH];
    rpt_state_e      state_d   [N_CH];

    assign sync = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d[0] = noisy_in;
        for (int unsigned k = 1; k < SYNC_STAGES; k++) begin
            sync_d[k] = sync_q[k-1];
        end
    end

    always_comb begin
        cand_d   = cand_q;
        clean_d  = clean_q;
        db_cnt_d = db_cnt_q;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (sync[i] != cand_q[i]) begin
                cand_d[i]   = sync[i];
                db_cnt_d[i] = '0;
            end else begin
                if (db_cnt_q[i] == DB_LAST) begin
                    clean_d[i] = cand_q[i];
                end
                if (db_cnt_q[i] != DB_SAT) begin
                    db_cnt_d[i] = db_cnt_q[i] + DW'(1);
                end
            end
        end
        press_d   = clean_d & ~clean_q;
        release_d = ~clean_d & clean_q;
    end

    // Repeat gating looks at clean_d so no repeat lands in the cycle clean_out falls.
    always_comb begin
        state_d   = state_q;
        rpt_cnt_d = rpt_cnt_q;
        rpt_d     = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            rpt_inc[i] = rpt_cnt_q[i] + RW'(1);
            if (!clean_d[i] || !rpt_en[i]) begin
                state_d[i]   = RPT_IDLE;
                rpt_cnt_d[i] = '0;
            end else if ((state_q[i] == RPT_IDLE && press_q[i]) || state_q[i] == RPT_DELAY_ST) begin
                state_d[i]   = RPT_DELAY_ST;
                rpt_cnt_d[i] = rpt_inc[i];
                if (rpt_inc[i] == RPT_DLY) begin
                    rpt_d[i]     = 1'b1;
                    rpt_cnt_d[i] = '0;
                    state_d[i]   = RPT_REPEAT;
                end
            end else if (state_q[i] == RPT_REPEAT) begin
                rpt_cnt_d[i] = rpt_inc[i];
                if (rpt_inc[i] == RPT_PER) begin
                    rpt_d[i]     = 1'b1;
                    rpt_cnt_d[i] = '0;
                end
            end
        end
        step_d = press_d | rpt_d;
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            sync_q    <= '{default: '0};
            cand_q    <= '0;
            clean_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
            step_q    <= '0;
            db_cnt_q  <= '{default: '0};
            rpt_cnt_q <= '{default: '0};
            state_q   <= '{default: RPT_IDLE};
        end else begin
            sync_q    <= sync_d;
            cand_q    <= cand_d;
            clean_q   <= clean_d;
            press_q   <= press_d;
            release_q <= release_d;
            step_q    <= step_d;
            db_cnt_q  <= db_cnt_d;
            rpt_cnt_q <= rpt_cnt_d;
            state_q   <= state_d;
        end
    end

    assign clean_out     = clean_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign step_pulse    = step_q;

endmodule
